// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//  Shared AHB3-Lite types and constants used by the command master and its
//  error-phase tracker.
//   htrans_e   - HTRANS encodings
//   hsize_e    - HSIZE encodings
//   dp_state_e - data-phase error tracking states
//   ahb_cmd_t  - one captured command (address-phase slot contents)
//   misaligned - address/size alignment test
// ---------------------------------------------------------------------------
package ahb_pkg;

   localparam int AHB_ADDR_W = 32;
   localparam int AHB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'b000,
      HSIZE_HALF  = 3'b001,
      HSIZE_WORD  = 3'b010,
      HSIZE_DWORD = 3'b011
   } hsize_e;

   typedef enum logic [0:0] {
      DP_RUN  = 1'b0,
      DP_ERR1 = 1'b1
   } dp_state_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef struct packed {
      logic [AHB_ADDR_W-1:0] addr;
      logic                  write;
      hsize_e                size;
      logic [AHB_DATA_W-1:0] wdata;
   } ahb_cmd_t;

   // True when any address bit below the transfer size is set.
   function automatic logic misaligned(input logic [7:0] addr_lo, input logic [2:0] size);
      return (addr_lo & ((8'd1 << size) - 8'd1)) != 8'd0;
   endfunction

endpackage

// File: rtl/ahb_lite_cmd_master_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master_if
//  Bundles the command stream, the response stream and the AHB-Lite bus of
//  the command master.
//   master modport - the view of ahb_lite_cmd_master (drives cmd_ready,
//                    rsp_*, HADDR..HWDATA; samples cmd_*, HRDATA/HREADY/HRESP)
//   slave modport  - the view of the command source and the subordinate
// ---------------------------------------------------------------------------
interface ahb_lite_cmd_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_write;
   logic [2:0]        cmd_size;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [3:0]        HPROT;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
      input  HRDATA, HREADY, HRESP,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
      output HRDATA, HREADY, HRESP,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
   );

endinterface

// File: rtl/ahb_master_err_fsm.sv
// ---------------------------------------------------------------------------
// ahb_master_err_fsm
//  Tracks the two-cycle AHB ERROR response of the current data phase and
//  decides whether the address-phase slot may drive NONSEQ.
//   clk, rst_n  - clock, asynchronous active-low reset
//   dp_real     - a real (bus-visible) transfer occupies the data phase
//   ap_bus_req  - the address-phase slot holds a transfer to put on the bus
//   hready      - bus ready
//   hresp       - 1 = ERROR
//   dp_state    - DP_RUN / DP_ERR1
//   htrans      - HTRANS to drive this cycle
// ---------------------------------------------------------------------------
module ahb_master_err_fsm
   import ahb_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      dp_real,
   input  logic      ap_bus_req,
   input  logic      hready,
   input  logic      hresp,
   output dp_state_e dp_state,
   output htrans_e   htrans
);

   dp_state_e state_q;
   dp_state_e state_d;

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DP_RUN;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      htrans  = IDLE;
      unique case (state_q)
         DP_RUN: begin
            // First ERROR cycle: the held address phase is withdrawn next cycle.
            if (dp_real && hresp && !hready) state_d = DP_ERR1;
            if (ap_bus_req)                  htrans  = NONSEQ;
         end
         DP_ERR1: begin
            if (hready) state_d = DP_RUN;
         end
         default: state_d = DP_RUN;
      endcase
   end

   assign dp_state = state_q;

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master
//  AHB3-Lite initiator turning a valid/ready command stream into single
//  NONSEQ transfers with pipelined address (AP) and data (DP) phases, and
//  returning one in-order response per command.
//   HCLK, HRESETn - bus clock, asynchronous active-low reset
//   bus           - ahb_lite_cmd_master_if.master: cmd_*, rsp_*, AHB signals
//  Misaligned commands occupy AP/DP like real transfers but never reach the
//  bus; they complete with rsp_err=1 in their place in the order.
// ---------------------------------------------------------------------------
module ahb_lite_cmd_master
   import ahb_pkg::*;
#(
   parameter int ADDR_W = AHB_ADDR_W,
   parameter int DATA_W = AHB_DATA_W
) (
   input logic                   HCLK,
   input logic                   HRESETn,
   ahb_lite_cmd_master_if.master bus
);

   ahb_cmd_t          ap_cmd;
   logic              ap_valid;
   logic              ap_misalign;
   logic              dp_valid;
   logic              dp_write;
   logic              dp_misalign;
   logic [DATA_W-1:0] hwdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   dp_state_e         dp_state;
   htrans_e           htrans;
   logic              accept;
   logic              ap_adv;
   logic              dp_done;

   // AP moves to DP only when the bus accepts it; in DP_ERR1 the address phase
   // was withdrawn, so AP stays put and is re-presented afterwards.
   assign ap_adv        = ap_valid && bus.HREADY && (dp_state == DP_RUN);
   assign dp_done       = dp_valid && bus.HREADY;
   assign bus.cmd_ready = (dp_state == DP_RUN) && (!ap_valid || bus.HREADY);
   assign accept        = bus.cmd_valid && bus.cmd_ready;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap_cmd      <= '0;
         ap_valid    <= 1'b0;
         ap_misalign <= 1'b0;
         dp_valid    <= 1'b0;
         dp_write    <= 1'b0;
         dp_misalign <= 1'b0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            ap_valid       <= 1'b1;
            ap_cmd.addr    <= AHB_ADDR_W'(bus.cmd_addr);
            ap_cmd.write   <= bus.cmd_write;
            ap_cmd.size    <= hsize_e'(bus.cmd_size);
            ap_cmd.wdata   <= AHB_DATA_W'(bus.cmd_wdata);
            ap_misalign    <= misaligned(bus.cmd_addr[7:0], bus.cmd_size);
         end else if (ap_adv) begin
            ap_valid <= 1'b0;
         end

         if (ap_adv) begin
            dp_valid    <= 1'b1;
            dp_write    <= ap_cmd.write;
            dp_misalign <= ap_misalign;
            hwdata_q    <= ap_cmd.wdata[DATA_W-1:0];
         end else if (dp_done) begin
            dp_valid <= 1'b0;
         end

         rsp_valid_q <= dp_done;
         rsp_rdata_q <= (dp_done && !dp_write && !dp_misalign) ? bus.HRDATA : '0;
         rsp_err_q   <= dp_done && (dp_misalign || bus.HRESP);
      end
   end

   ahb_master_err_fsm u_err_fsm (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .dp_real    (dp_valid && !dp_misalign),
      .ap_bus_req (ap_valid && !ap_misalign),
      .hready     (bus.HREADY),
      .hresp      (bus.HRESP),
      .dp_state   (dp_state),
      .htrans     (htrans)
   );

   assign bus.HADDR     = ap_cmd.addr[ADDR_W-1:0];
   assign bus.HTRANS    = htrans;
   assign bus.HWRITE    = ap_cmd.write;
   assign bus.HSIZE     = ap_cmd.size;
   assign bus.HBURST    = HBURST_SINGLE;
   assign bus.HPROT     = HPROT_DEFAULT;
   assign bus.HWDATA    = hwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_cmd_master
//  Bench for ahb_lite_cmd_master: a behavioural AHB-Lite subordinate (2 wait
//  states at 0x20, ERROR above 0xFFF), a reference memory, and an in-order
//  response scoreboard.
// ---------------------------------------------------------------------------
module tb_ahb_lite_cmd_master;
   import ahb_pkg::*;

   logic HCLK = 1'b0;
   logic HRESETn;
   always #5 HCLK = ~HCLK;

   ahb_lite_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ahb_lite_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge HCLK) cyc <= cyc + 1;

   // ---------------- subordinate model ----------------
   logic [31:0] mem [0:1023];
   logic        s_pend;
   logic        s_write;
   logic [31:0] s_addr;
   int          s_wait;
   int          s_err;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s_pend  <= 1'b0;
         s_write <= 1'b0;
         s_addr  <= '0;
         s_wait  <= 0;
         s_err   <= 0;
      end else if (bus.HREADY) begin
         if (s_pend && s_write && s_err == 0) mem[s_addr[11:2]] <= bus.HWDATA;
         s_pend  <= (bus.HTRANS == NONSEQ);
         s_addr  <= bus.HADDR;
         s_write <= bus.HWRITE;
         s_wait  <= (bus.HADDR == 32'h20) ? 2 : 0;
         s_err   <= (bus.HADDR[31:12] != 20'h0) ? 1 : 0;
      end else begin
         if (s_wait > 0) s_wait <= s_wait - 1;
         if (s_err == 1) s_err <= 2;
      end
   end

   assign bus.HREADY = !s_pend || (s_err == 2) || (s_err == 0 && s_wait == 0);
   assign bus.HRESP  = s_pend && (s_err != 0);
   assign bus.HRDATA = (s_pend && !s_write && s_err == 0 && s_wait == 0) ? mem[s_addr[11:2]] : 32'h0;

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] ref_mem [int];
   int          last_lat;

   function automatic logic ref_misaligned(input logic [31:0] a, input logic [2:0] s);
      case (s)
         3'd0:    return 1'b0;
         3'd1:    return a[0];
         3'd2:    return a[1:0] != 2'b00;
         3'd3:    return a[2:0] != 3'b000;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      int idx = int'(a[11:2]);
      return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
   endfunction

   always @(negedge HCLK) begin
      if (HRESETn && bus.rsp_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid rdata=%h err=%b, required none", bus.rsp_rdata, bus.rsp_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
               errors++;
               $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                        bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
            last_lat = cyc - e.acc;
            checks++;
            if (last_lat < 3) begin
               errors++;
               $display("FAIL rsp_latency: got %0d cycles, required >= 3", last_lat);
            end
         end
      end
   end

   // ---------------- bus monitor ----------------
   int          nonseq_cnt = 0;
   int          run_len    = 0;
   int          max_run    = 0;
   int          wait_cnt   = 0;
   int          err2_seen  = 0;
   logic        prev_stall = 1'b0;
   logic        prev_err1  = 1'b0;
   logic [31:0] prev_addr  = '0;

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         prev_stall = 1'b0;
         prev_err1  = 1'b0;
         run_len    = 0;
      end else begin
         if (bus.HTRANS == NONSEQ && bus.HREADY) begin
            nonseq_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (!bus.HREADY && !bus.HRESP) wait_cnt++;
         if (prev_stall) begin
            checks++;
            if (bus.HADDR !== prev_addr || bus.HTRANS !== NONSEQ) begin
               errors++;
               $display("FAIL ap_stable: got HADDR=%h HTRANS=%b, required HADDR=%h HTRANS=10",
                        bus.HADDR, bus.HTRANS, prev_addr);
            end
         end
         if (prev_err1 && bus.HRESP && bus.HREADY) begin
            err2_seen++;
            checks++;
            if (bus.HTRANS !== IDLE) begin
               errors++;
               $display("FAIL err2_idle: got HTRANS=%b, required 00", bus.HTRANS);
            end
         end
         prev_stall = (bus.HTRANS == NONSEQ) && !bus.HREADY && !bus.HRESP;
         prev_err1  = bus.HRESP && !bus.HREADY;
         prev_addr  = bus.HADDR;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a negedge; returns at the negedge after acceptance with
   // cmd_valid still high so calls can be chained back to back.
   task automatic send(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata);
      exp_t e;
      int   n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_write = wr;
      bus.cmd_size  = size;
      bus.cmd_wdata = wdata;
      while (!bus.cmd_ready && n < 100) begin
         @(negedge HCLK);
         n++;
      end
      if (!bus.cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, required 1", n);
         bus.cmd_valid = 1'b0;
      end else begin
         e.err   = ref_misaligned(addr, size) || (addr[31:12] != 20'h0);
         e.rdata = (wr || e.err) ? 32'h0 : ref_read(addr);
         e.acc   = cyc;
         if (wr && !e.err) ref_mem[int'(addr[11:2])] = wdata;
         sb.push_back(e);
         @(negedge HCLK);
      end
   endtask

   task automatic cmd_idle();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge HCLK);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
         sb.delete();
      end
      @(negedge HCLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      HRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_write = 1'b0;
      bus.cmd_size  = '0;
      bus.cmd_wdata = '0;
      repeat (3) @(negedge HCLK);
      checks++;
      if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'b000) begin
         errors++;
         $display("FAIL reset_ap: got HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%b, required all 0",
                  bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE);
      end
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.HWDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_rsp: got rsp_valid=%b rsp_rdata=%h rsp_err=%b HWDATA=%h, required all 0",
                  bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.HWDATA);
      end
      checks++;
      if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011) begin
         errors++;
         $display("FAIL reset_const: got HBURST=%b HPROT=%b, required 000 0011", bus.HBURST, bus.HPROT);
      end
      HRESETn = 1'b1;
      @(negedge HCLK);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.HTRANS !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got cmd_ready=%b HTRANS=%b, required 1 00", bus.cmd_ready, bus.HTRANS);
      end
   endtask

   task automatic test_single();
      int n0 = nonseq_cnt;
      max_run = 0;
      send(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
      cmd_idle();
      wait_drain("single_wr");
      checks++;
      if (last_lat !== 3) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles, required 3", last_lat);
      end
      send(32'h10, 1'b0, 3'd2, 32'h0);
      cmd_idle();
      wait_drain("single_rd");
      checks++;
      if (nonseq_cnt - n0 !== 2 || max_run !== 1) begin
         errors++;
         $display("FAIL single_nonseq: got %0d transfers max run %0d, required 2 and 1",
                  nonseq_cnt - n0, max_run);
      end
   endtask

   task automatic test_back_to_back();
      int n0 = nonseq_cnt;
      max_run = 0;
      for (int i = 0; i < 4; i++) send(32'(i * 4), 1'b1, 3'd2, 32'hA5A50000 + 32'(i));
      cmd_idle();
      wait_drain("b2b_wr");
      checks++;
      if (nonseq_cnt - n0 !== 4 || max_run !== 4) begin
         errors++;
         $display("FAIL b2b_nonseq: got %0d transfers max run %0d, required 4 and 4",
                  nonseq_cnt - n0, max_run);
      end
      for (int i = 0; i < 4; i++) send(32'(i * 4), 1'b0, 3'd2, 32'h0);
      cmd_idle();
      wait_drain("b2b_rd");
   endtask

   task automatic test_wait_states();
      int w0;
      send(32'h20, 1'b1, 3'd2, 32'h12345678);
      cmd_idle();
      wait_drain("wait_wr");
      w0 = wait_cnt;
      send(32'h20, 1'b0, 3'd2, 32'h0);
      send(32'h10, 1'b0, 3'd2, 32'h0);
      cmd_idle();
      wait_drain("wait_rd");
      checks++;
      if (wait_cnt - w0 !== 2) begin
         errors++;
         $display("FAIL wait_count: got %0d wait cycles, required 2", wait_cnt - w0);
      end
   endtask

   task automatic test_error();
      int n0 = nonseq_cnt;
      int e0 = err2_seen;
      send(32'hF000_0000, 1'b1, 3'd2, 32'hBAD0BAD0);
      send(32'h10, 1'b0, 3'd2, 32'h0);
      cmd_idle();
      wait_drain("error");
      checks++;
      if (err2_seen - e0 !== 1 || nonseq_cnt - n0 !== 2) begin
         errors++;
         $display("FAIL error_seq: got %0d error completions %0d transfers, required 1 and 2",
                  err2_seen - e0, nonseq_cnt - n0);
      end
   endtask

   task automatic test_misalign();
      int n0 = nonseq_cnt;
      send(32'h3, 1'b0, 3'd2, 32'h0);
      send(32'h11, 1'b1, 3'd1, 32'h55AA55AA);
      cmd_idle();
      wait_drain("misalign");
      checks++;
      if (nonseq_cnt - n0 !== 0) begin
         errors++;
         $display("FAIL misalign_bus: got %0d transfers, required 0", nonseq_cnt - n0);
      end
      send(32'h7, 1'b0, 3'd1, 32'h0);
      send(32'h13, 1'b0, 3'd0, 32'h0);
      cmd_idle();
      wait_drain("misalign_mix");
      checks++;
      if (nonseq_cnt - n0 !== 1) begin
         errors++;
         $display("FAIL misalign_mix_bus: got %0d transfers, required 1", nonseq_cnt - n0);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int n0;
      send(32'h20, 1'b0, 3'd2, 32'h0);
      cmd_idle();
      while (!(s_pend && !bus.HREADY) && n < 20) begin
         @(negedge HCLK);
         n++;
      end
      checks++;
      if (!(s_pend && !bus.HREADY)) begin
         errors++;
         $display("FAIL rstmid_wait: no waited data phase after %0d cycles, required one", n);
      end
      #2;
      HRESETn = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.rsp_valid !== 1'b0 || bus.HWDATA !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_outputs: got HTRANS=%b HADDR=%h rsp_valid=%b HWDATA=%h, required all 0",
                  bus.HTRANS, bus.HADDR, bus.rsp_valid, bus.HWDATA);
      end
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (3) @(negedge HCLK);
      n0 = nonseq_cnt;
      send(32'h44, 1'b1, 3'd2, 32'hCAFEF00D);
      send(32'h44, 1'b0, 3'd2, 32'h0);
      cmd_idle();
      wait_drain("rstmid");
      checks++;
      if (nonseq_cnt - n0 !== 2) begin
         errors++;
         $display("FAIL rstmid_clean: got %0d transfers, required 2", nonseq_cnt - n0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wait_states();
      test_error();
      test_misalign();
      test_reset_mid();
      repeat (3) @(negedge HCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
